// File: rtl/calc_pkg.sv
// Shared constants for the calculator core and the seven-segment display stage.
// Holds the state encoding, key codes, operator encoding and operand limit.
package calc_pkg;

    localparam logic [2:0] S_FIRST    = 3'd0;
    localparam logic [2:0] S_CALCUL   = 3'd1;
    localparam logic [2:0] S_SECOND   = 3'd2;
    localparam logic [2:0] S_ENTER    = 3'd3;
    localparam logic [2:0] S_RESULT   = 3'd4;
    localparam logic [2:0] S_CONTINUE = 3'd5;

    typedef enum logic [2:0] {
        ST_FIRST    = S_FIRST,
        ST_CALCUL   = S_CALCUL,
        ST_SECOND   = S_SECOND,
        ST_ENTER    = S_ENTER,
        ST_RESULT   = S_RESULT,
        ST_CONTINUE = S_CONTINUE
    } state_t;

    localparam logic [3:0] KEY_DIGIT_MAX = 4'd9;
    localparam logic [3:0] KEY_ADD       = 4'd10;
    localparam logic [3:0] KEY_SUB       = 4'd11;
    localparam logic [3:0] KEY_MUL       = 4'd12;
    localparam logic [3:0] KEY_DIV       = 4'd13;
    localparam logic [3:0] KEY_ENT       = 4'd14;
    localparam logic [3:0] KEY_CLR       = 4'd15;

    localparam logic [1:0] OP_ADD = 2'd0;
    localparam logic [1:0] OP_SUB = 2'd1;
    localparam logic [1:0] OP_MUL = 2'd2;
    localparam logic [1:0] OP_DIV = 2'd3;

    localparam int MAX_OPERAND = 9999;

    // Operator keys are contiguous, so the op code is the offset from KEY_ADD.
    function automatic logic [1:0] key_to_op(input logic [3:0] key);
        logic [3:0] ofs;
        ofs = key - KEY_ADD;
        return ofs[1:0];
    endfunction

endpackage

// File: rtl/calc_alu.sv
// Combinational calculator arithmetic: add, |sub| with sign, mul, floor div.
// No latency, no flow control; divide by zero yields 0 with err set.
module calc_alu
    import calc_pkg::*;
(
    input  logic [15:0] a,
    input  logic [15:0] b,
    input  logic [1:0]  op,
    output logic [31:0] result,
    output logic        neg,
    output logic        err
);

    always_comb begin
        result = '0;
        neg    = 1'b0;
        err    = 1'b0;
        case (op)
            OP_ADD: result = {16'd0, a} + {16'd0, b};
            OP_SUB: begin
                if (a < b) begin
                    neg    = 1'b1;
                    result = {16'd0, b - a};
                end else begin
                    result = {16'd0, a - b};
                end
            end
            OP_MUL: result = {16'd0, a} * {16'd0, b};
            OP_DIV: begin
                if (b == 16'd0) err = 1'b1;
                else            result = {16'd0, a / b};
            end
        endcase
    end

endmodule

// File: rtl/calc_core.sv
// Calculator control FSM: builds decimal operands from key strobes, result registered in ENTER.
// Keys take effect one edge after acceptance; result one edge after ENTER; no backpressure (ENTER drops keys).
module calc_core
    import calc_pkg::*;
#(
    parameter int MAX_DIGITS = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        key_valid,
    input  logic [3:0]  key_code,
    output logic [15:0] OP_A,
    output logic [15:0] OP_B,
    output logic [31:0] OP_Result,
    output logic [2:0]  current_state,
    output logic        neg,
    output logic        err
);

    // Operands below this value still have room for one more digit.
    localparam logic [15:0] APPEND_LIMIT = 16'(10 ** (MAX_DIGITS - 1));

    state_t      state_q, state_nxt;
    logic [15:0] a_q, a_nxt, b_q, b_nxt;
    logic [1:0]  op_q, op_nxt;
    logic [31:0] res_q, res_nxt;
    logic        neg_q, neg_nxt, err_q, err_nxt;

    logic        is_digit, is_op, is_ent, is_clr;
    logic [15:0] digit;
    logic [31:0] alu_res;
    logic        alu_neg, alu_err;

    assign is_digit = key_valid && (key_code <= KEY_DIGIT_MAX);
    assign is_op    = key_valid && (key_code >= KEY_ADD) && (key_code <= KEY_DIV);
    assign is_ent   = key_valid && (key_code == KEY_ENT);
    assign is_clr   = key_valid && (key_code == KEY_CLR);
    assign digit    = {12'd0, key_code};

    calc_alu u_alu (
        .a      (a_q),
        .b      (b_q),
        .op     (op_q),
        .result (alu_res),
        .neg    (alu_neg),
        .err    (alu_err)
    );

    always_comb begin
        state_nxt = state_q;
        a_nxt     = a_q;
        b_nxt     = b_q;
        op_nxt    = op_q;
        res_nxt   = res_q;
        neg_nxt   = neg_q;
        err_nxt   = err_q;
        if (is_clr) begin
            state_nxt = ST_FIRST;
            a_nxt     = '0;
            b_nxt     = '0;
            op_nxt    = OP_ADD;
            res_nxt   = '0;
            neg_nxt   = 1'b0;
            err_nxt   = 1'b0;
        end else begin
            case (state_q)
                ST_FIRST: begin
                    if (is_digit && (a_q < APPEND_LIMIT)) begin
                        a_nxt = a_q * 16'd10 + digit;
                    end else if (is_op) begin
                        op_nxt    = key_to_op(key_code);
                        state_nxt = ST_CALCUL;
                    end
                end
                ST_CALCUL, ST_CONTINUE: begin
                    if (is_digit) begin
                        b_nxt     = digit;
                        state_nxt = ST_SECOND;
                    end else if (is_op) begin
                        op_nxt = key_to_op(key_code);
                    end
                end
                ST_SECOND: begin
                    if (is_digit && (b_q < APPEND_LIMIT)) begin
                        b_nxt = b_q * 16'd10 + digit;
                    end else if (is_ent) begin
                        state_nxt = ST_ENTER;
                    end
                end
                ST_ENTER: begin
                    res_nxt   = alu_res;
                    neg_nxt   = alu_neg;
                    err_nxt   = alu_err;
                    state_nxt = ST_RESULT;
                end
                ST_RESULT: begin
                    if (is_digit) begin
                        a_nxt     = digit;
                        b_nxt     = '0;
                        res_nxt   = '0;
                        neg_nxt   = 1'b0;
                        err_nxt   = 1'b0;
                        state_nxt = ST_FIRST;
                    end else if (is_op) begin
                        // Chained calculation keeps only the low four digits of the magnitude.
                        a_nxt     = 16'(res_q % 32'(MAX_OPERAND + 1));
                        b_nxt     = '0;
                        op_nxt    = key_to_op(key_code);
                        neg_nxt   = 1'b0;
                        err_nxt   = 1'b0;
                        state_nxt = ST_CONTINUE;
                    end
                end
                default: state_nxt = ST_FIRST;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= ST_FIRST;
        else        state_q <= state_nxt;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q   <= '0;
            b_q   <= '0;
            op_q  <= OP_ADD;
            res_q <= '0;
            neg_q <= 1'b0;
            err_q <= 1'b0;
        end else begin
            a_q   <= a_nxt;
            b_q   <= b_nxt;
            op_q  <= op_nxt;
            res_q <= res_nxt;
            neg_q <= neg_nxt;
            err_q <= err_nxt;
        end
    end

    assign OP_A          = a_q;
    assign OP_B          = b_q;
    assign OP_Result     = res_q;
    assign current_state = state_q;
    assign neg           = neg_q;
    assign err           = err_q;

endmodule
